// File: rtl/histeq_pkg.sv
// Shared histogram-equalizer definitions: bin geometry, valid-bin tag, the
// FSM state set and the m3 LUT word layout.
package histeq_pkg;

  localparam int BINS  = 256;
  localparam int BIN_W = 8;
  localparam int CNT_W = 24;
  localparam int DIV_W = 32;
  localparam logic [15:0] TAG = 16'hAAAA;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_SCAN_TAIL,
    S_MAP_RD,
    S_MAP_ACC,
    S_MAP_DIV,
    S_MAP_WR,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [95:0] rsvd;
    logic [15:0] tag;
    logic [7:0]  pad;
    logic [7:0]  map;
  } m3_word_t;

  // Words whose tag field is not TAG were never written by the input stage.
  function automatic logic [15:0] bin_count(input logic [127:0] w);
    return (w[31:16] == TAG) ? w[15:0] : 16'd0;
  endfunction

endpackage

// File: rtl/serial_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; the load edge already
// performs the first step, so the quotient is ready W cycles after start_i.
module serial_divider #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] quotient_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam int CW = $clog2(W);

  logic [W-1:0]  rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic [W-1:0]  rem_in, quo_in, dvs_in, rem_nx, quo_nx;
  logic [W:0]    trial;

  always_comb begin
    rem_in = start_i ? '0 : rem_q;
    quo_in = start_i ? dividend_i : quo_q;
    dvs_in = start_i ? divisor_i : dvs_q;
    trial  = {rem_in, quo_in[W-1]} - {1'b0, dvs_in};
    // Remainder stays below the divisor, so trial[W] is a clean borrow flag.
    if (trial[W]) begin
      rem_nx = {rem_in[W-2:0], quo_in[W-1]};
      quo_nx = {quo_in[W-2:0], 1'b0};
    end else begin
      rem_nx = trial[W-1:0];
      quo_nx = {quo_in[W-2:0], 1'b1};
    end
  end

  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start_i) begin
      rem_d  = rem_nx;
      quo_d  = quo_nx;
      dvs_d  = divisor_i;
      cnt_d  = CW'(W - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = rem_nx;
      quo_d = quo_nx;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign quotient_o = quo_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: rtl/cdf_pipeline.sv
// Histogram-equalizer stage 2: scans the m2 histogram for total and cdf_min, then
// builds the 256-entry equalization LUT in m3 on a fixed 35-cycle-per-bin schedule.
module cdf_pipeline
  import histeq_pkg::*;
(
  input  logic         clock,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [127:0] m2ReadVal_i,
  output logic [15:0]  m2ReadAddr_o,
  output logic [15:0]  m3WriteAddr_o,
  output logic [127:0] m3WriteVal_o,
  output logic         m3WE_o,
  output logic         done_o
);

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [CNT_W-1:0]   total_q, total_d, cdf_q, cdf_d, cdf_min_q, cdf_min_d;
  logic               min_seen_q, min_seen_d, den_zero_q, den_zero_d;
  logic [15:0]        m3_addr_q, m3_addr_d;
  m3_word_t           m3_val_q, m3_val_d;
  logic               m3_we_q, m3_we_d, done_q, done_d;

  logic [CNT_W-1:0]   cnt, cdf_acc, diff;
  logic [DIV_W-1:0]   div_num, div_den, div_quo;
  logic               div_start, div_busy, div_done, div_fin;
  logic [7:0]         map;

  serial_divider #(.W(DIV_W)) u_div (
    .clock      (clock),
    .rst_n      (rst_n),
    .start_i    (div_start),
    .dividend_i (div_num),
    .divisor_i  (div_den),
    .quotient_o (div_quo),
    .busy_o     (div_busy),
    .done_o     (div_done)
  );

  assign cnt       = CNT_W'(bin_count(m2ReadVal_i));
  assign cdf_acc   = cdf_q + cnt;
  // Bins below the first populated one would go negative; pin them to zero.
  assign diff      = (cdf_acc >= cdf_min_q) ? (cdf_acc - cdf_min_q) : '0;
  assign div_num   = DIV_W'(diff) * DIV_W'(255);
  assign div_den   = DIV_W'(total_q - cdf_min_q);
  assign div_start = (state_q == S_MAP_ACC);
  assign div_fin   = div_done & ~div_busy;
  assign map       = den_zero_q ? bin_q : ((div_quo > DIV_W'(255)) ? 8'hFF : div_quo[7:0]);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q != S_IDLE && !start_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:      if (start_i) state_d = S_SCAN;
        S_SCAN:      if (bin_q == BIN_W'(BINS - 1)) state_d = S_SCAN_TAIL;
        S_SCAN_TAIL: state_d = S_MAP_RD;
        S_MAP_RD:    state_d = S_MAP_ACC;
        S_MAP_ACC:   state_d = S_MAP_DIV;
        S_MAP_DIV:   if (div_fin) state_d = S_MAP_WR;
        S_MAP_WR:    state_d = (bin_q == BIN_W'(BINS - 1)) ? S_DONE : S_MAP_RD;
        S_DONE:      state_d = S_DONE;
        default:     state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bin_d      = bin_q;
    total_d    = total_q;
    cdf_d      = cdf_q;
    cdf_min_d  = cdf_min_q;
    min_seen_d = min_seen_q;
    den_zero_d = den_zero_q;
    m3_addr_d  = m3_addr_q;
    m3_val_d   = m3_val_q;
    m3_we_d    = (state_d == S_MAP_WR);
    done_d     = (state_d == S_DONE);
    if (state_q == S_IDLE || state_d == S_IDLE) begin
      bin_d      = '0;
      total_d    = '0;
      cdf_d      = '0;
      cdf_min_d  = '0;
      min_seen_d = 1'b0;
      den_zero_d = 1'b0;
    end else begin
      case (state_q)
        S_SCAN, S_SCAN_TAIL: begin
          // Read data lags the address by a cycle: nothing valid yet at bin 0 of SCAN.
          if (state_q == S_SCAN) bin_d = bin_q + BIN_W'(1);
          if (state_q == S_SCAN_TAIL || bin_q != '0) begin
            total_d = total_q + cnt;
            if (!min_seen_q && cnt != '0) begin
              cdf_min_d  = cnt;
              min_seen_d = 1'b1;
            end
          end
        end
        S_MAP_ACC: begin
          cdf_d      = cdf_acc;
          den_zero_d = (total_q == cdf_min_q);
        end
        S_MAP_DIV: begin
          if (state_d == S_MAP_WR) begin
            m3_addr_d = {8'd0, bin_q};
            m3_val_d  = '{rsvd: '0, tag: TAG, pad: '0, map: map};
          end
        end
        S_MAP_WR: bin_d = bin_q + BIN_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      bin_q      <= '0;
      total_q    <= '0;
      cdf_q      <= '0;
      cdf_min_q  <= '0;
      min_seen_q <= 1'b0;
      den_zero_q <= 1'b0;
      m3_addr_q  <= '0;
      m3_val_q   <= '0;
      m3_we_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      bin_q      <= bin_d;
      total_q    <= total_d;
      cdf_q      <= cdf_d;
      cdf_min_q  <= cdf_min_d;
      min_seen_q <= min_seen_d;
      den_zero_q <= den_zero_d;
      m3_addr_q  <= m3_addr_d;
      m3_val_q   <= m3_val_d;
      m3_we_q    <= m3_we_d;
      done_q     <= done_d;
    end
  end

  assign m2ReadAddr_o  = {8'd0, bin_q};
  assign m3WriteAddr_o = m3_addr_q;
  assign m3WriteVal_o  = m3_val_q;
  assign m3WE_o        = m3_we_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_cdf_pipeline.sv
// Bench for cdf_pipeline: synchronous m2 model, m3 capture, and an arithmetic
// reference LUT computed straight from the histogram.
module tb_cdf_pipeline;

  logic         clock = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] m2_val;
  logic [15:0]  m2_addr, m3_addr;
  logic [127:0] m3_val;
  logic         m3_we, done;

  logic [127:0] m2mem   [256];
  logic [127:0] got_val [256];
  int           exp_lut [256];
  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc, pulses, last_we, done_cyc, bad_we, bad_done;

  cdf_pipeline dut (
    .clock         (clock),
    .rst_n         (rst_n),
    .start_i       (start),
    .m2ReadVal_i   (m2_val),
    .m2ReadAddr_o  (m2_addr),
    .m3WriteAddr_o (m3_addr),
    .m3WriteVal_o  (m3_val),
    .m3WE_o        (m3_we),
    .done_o        (done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) m2_val <= m2mem[m2_addr[7:0]];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic void model();
    longint c[256];
    longint total = 0, cmin = 0, den, cdf = 0;
    bit found = 0;
    for (int k = 0; k < 256; k++) begin
      c[k] = (m2mem[k][31:16] == 16'hAAAA) ? longint'(m2mem[k][15:0]) : 0;
      total += c[k];
      if (!found && c[k] != 0) begin
        cmin  = c[k];
        found = 1;
      end
    end
    den = total - cmin;
    for (int k = 0; k < 256; k++) begin
      cdf += c[k];
      if (den == 0) exp_lut[k] = k;
      else          exp_lut[k] = int'(((cdf > cmin ? cdf - cmin : 0) * 255) / den);
    end
  endfunction

  function automatic void fill_random();
    for (int k = 0; k < 256; k++) begin
      case ($urandom_range(0, 3))
        0:       m2mem[k] = '0;
        1:       m2mem[k] = {$urandom(), $urandom(), $urandom(), 16'h5555, 16'($urandom_range(1, 60000))};
        default: m2mem[k] = {$urandom(), $urandom(), $urandom(), 16'hAAAA, 16'($urandom_range(0, 5000))};
      endcase
    end
  endfunction

  // Starts a run at a negedge (that cycle is cycle 0) and checks the whole LUT.
  task automatic run_full(input string name);
    model();
    for (int k = 0; k < 256; k++) got_val[k] = 'x;
    pulses = 0; last_we = -1; done_cyc = -1;
    @(negedge clock);
    start = 1'b1;
    cyc = 0;
    while (cyc < 9400 && done_cyc < 0) begin
      @(negedge clock);
      cyc++;
      if (m3_we === 1'b1) begin
        got_val[m3_addr[7:0]] = m3_val;
        pulses++;
        last_we = cyc;
      end
      if (done === 1'b1) done_cyc = cyc;
    end
    chk({name, "_pulses"}, 128'(pulses), 128'd256);
    chk({name, "_last_we_cycle"}, 128'(last_we), 128'd9217);
    chk({name, "_done_cycle"}, 128'(done_cyc), 128'd9218);
    for (int k = 0; k < 256; k++)
      chk($sformatf("%s_m3[%0d]", name, k), got_val[k], {96'h0, 16'hAAAA, 8'h00, 8'(exp_lut[k])});
    repeat (3) @(negedge clock);
    chk({name, "_done_held"}, 128'(done), 128'd1);
    start = 1'b0;
    @(negedge clock);
    chk({name, "_done_cleared"}, 128'(done), 128'd0);
    chk({name, "_we_after"}, 128'(m3_we), 128'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 256; k++) m2mem[k] = '0;
    #1;
    chk("reset_m2addr", 128'(m2_addr), 128'd0);
    chk("reset_m3addr", 128'(m3_addr), 128'd0);
    chk("reset_m3val", m3_val, 128'd0);
    chk("reset_we", 128'(m3_we), 128'd0);
    chk("reset_done", 128'(done), 128'd0);
    repeat (3) @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);

    for (int k = 0; k < 256; k++) m2mem[k] = {96'h0, 16'hAAAA, 16'd4};
    run_full("uniform");

    for (int k = 0; k < 256; k++) m2mem[k] = '0;
    m2mem[10]  = {96'h0, 16'hAAAA, 16'd16};
    m2mem[200] = {96'h0, 16'hAAAA, 16'd16};
    run_full("sparse");

    for (int k = 0; k < 256; k++) m2mem[k] = '0;
    m2mem[77] = {96'h0, 16'hAAAA, 16'd64};
    run_full("single");

    fill_random();
    m2mem[5] = {96'h0, 16'h1234, 16'd999};
    run_full("garbage");

    // Abort: start is low during cycle 5000.
    fill_random();
    @(negedge clock);
    start = 1'b1;
    cyc = 0;
    while (cyc < 5000) begin
      @(negedge clock);
      cyc++;
    end
    start = 1'b0;
    bad_we = 0; bad_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (m3_we !== 1'b0) bad_we++;
      if (done !== 1'b0) bad_done++;
      if (i == 4) chk("abort_idle_addr", 128'(m2_addr), 128'd0);
    end
    chk("abort_we_pulses", 128'(bad_we), 128'd0);
    chk("abort_done_high", 128'(bad_done), 128'd0);
    run_full("abort_rerun");

    // Asynchronous reset mid-divide.
    fill_random();
    @(negedge clock);
    start = 1'b1;
    cyc = 0;
    while (cyc < 300) begin
      @(negedge clock);
      cyc++;
    end
    #1;
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    chk("arst_m2addr", 128'(m2_addr), 128'd0);
    chk("arst_m3addr", 128'(m3_addr), 128'd0);
    chk("arst_m3val", m3_val, 128'd0);
    chk("arst_we", 128'(m3_we), 128'd0);
    chk("arst_done", 128'(done), 128'd0);
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    run_full("reset_rerun");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
